// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-subset datapath: opcodes, widths, fetch FSM states
// and the branch-offset helper used by the next-PC logic.
package mips_pkg;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  // Word offset to byte offset, sign-extended to the full address width.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage (master) and instruction memory plus the
// decode/execute side (slave).
interface fetch_unit_if import mips_pkg::*; ();

  // imem: a transfer happens in any cycle with imem_req & imem_ready; imem_req and
  // imem_addr hold steady until then. decode: instr is consumed in any cycle with
  // instr_valid & instr_ack, and the resolve inputs are only sampled in that cycle.
  logic                imem_req;
  logic [31:0]         imem_addr;
  logic                imem_ready;
  logic [INSTR_W-1:0]  imem_rdata;
  logic [INSTR_W-1:0]  instr;
  logic [OPCODE_W-1:0] opcode;
  logic                instr_valid;
  logic                instr_ack;
  logic [31:0]         pc;
  logic [31:0]         pc_plus4;
  logic                beq;
  logic                bne;
  logic                jump;
  logic                zero;
  logic [15:0]         branch_imm;
  logic [25:0]         jump_target;

  modport master (
    output imem_req, imem_addr, instr, opcode, instr_valid, pc, pc_plus4,
    input  imem_ready, imem_rdata, instr_ack, beq, bne, jump, zero,
           branch_imm, jump_target
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, instr_valid, pc, pc_plus4,
    output imem_ready, imem_rdata, instr_ack, beq, bne, jump, zero,
           branch_imm, jump_target
  );

endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// Next-PC selection: jump beats branch, branches are relative to pc_plus4,
// all arithmetic wraps modulo 2^32.
module next_pc_calc import mips_pkg::*; (
    input  logic [31:0] pc_plus4,
    input  logic        beq,
    input  logic        bne,
    input  logic        jump,
    input  logic        zero,
    input  logic [15:0] branch_imm,
    input  logic [25:0] jump_target,
    output logic [31:0] next_pc
);

    logic taken;

    // beq and bne together is legal; the formula alone decides.
    assign taken = (beq & zero) | (bne & ~zero);

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], jump_target, 2'b00};
        end else if (taken) begin
            next_pc = pc_plus4 + branch_offset(branch_imm);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word at a time from imem and
// hands it downstream, then advances the PC on the downstream ack.
module fetch_unit import mips_pkg::*; #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus,
    output fetch_state_t dbg_state
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]         state;
    logic [31:0]        pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;
    logic               req_q;
    logic [31:0]        pc_plus4;
    logic [31:0]        next_pc;

    assign pc_plus4 = pc_q + 32'd4;

    next_pc_calc u_next_pc_calc (
        .pc_plus4    (pc_plus4),
        .beq         (bus.beq),
        .bne         (bus.bne),
        .jump        (bus.jump),
        .zero        (bus.zero),
        .branch_imm  (bus.branch_imm),
        .jump_target (bus.jump_target),
        .next_pc     (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    // req is only low here for the first cycle out of reset.
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (bus.imem_ready) begin
                        instr_q <= bus.imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.instr_ack) begin
                        pc_q    <= next_pc;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state   <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[INSTR_W-1 -: OPCODE_W];
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign dbg_state       = fetch_state_t'(state);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the single-issue MIPS-subset datapath, sitting directly upstream of the main control decoder. It holds the program counter and fetches one 32-bit instruction at a time from instruction memory over a req/ready handshake. It presents the instruction, with a valid/ack handshake, to the decode/execute side. It consumes that side's Beq/Bne/Jump decisions plus the ALU Zero flag to compute the next PC.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded by reset; must be word aligned.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high until imem_ready.
- imem_addr  out  32  fetch address (= pc); stable while imem_req high.
- imem_ready  in  1  memory accepts request; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  captured instruction.
- opcode  out  6  instr[31:26], fed to the control decoder.
- instr_valid  out  1  instr/pc outputs are valid.
- instr_ack  in  1  downstream has consumed instr; resolve inputs valid this cycle.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc + 4.
- beq, bne, jump  in  1 each  control decisions for the current instruction.
- zero  in  1  ALU zero flag for the current instruction.
- branch_imm  in  16  instr[15:0] branch offset (words, signed).
- jump_target  in  26  instr[25:0].

## Operation
- FSM states: FETCH, HOLD.
- FETCH
  - imem_req=1, imem_addr=pc.
  - On imem_ready: capture imem_rdata into instr, set instr_valid=1, go to HOLD.
- HOLD
  - instr_valid=1; instr and pc held stable.
  - On instr_ack: load pc with next_pc, clear instr_valid, go to FETCH.
- next_pc, evaluated on the ack cycle:
  - jump=1: {pc_plus4[31:28], jump_target, 2'b00}.
  - else taken = (beq & zero) | (bne & ~zero); if taken: pc_plus4 + (sext(branch_imm) << 2).
  - else pc_plus4.
- Priority: jump over branch. beq and bne both high is legal and resolves by the taken formula.
- Arithmetic is 32-bit modulo. Wrap from 32'hFFFF_FFFC to 0 is silent; there is no overflow flag.
- Branch target is relative to pc_plus4, not pc.
- instr_ack while instr_valid=0 is ignored. Resolve inputs are don't-care outside ack cycles.
- imem_ready while imem_req=0 is ignored.
- Reset mid-operation, in any state: drops the captured instr and any outstanding request. A memory response in the reset cycle is discarded.

## Timing
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, state=FETCH.
- Outputs are registered except combinational imem_addr, opcode and pc_plus4.
- First request: imem_req=1 in the first cycle after reset deasserts.
- imem_ready in cycle N: instr_valid=1 in N+1.
- instr_ack in cycle M: new pc and imem_req=1 in M+1.
- Best-case throughput, with ready and ack both immediate: one instruction per 2 cycles.
- No request is issued while in HOLD; at most one fetch is outstanding.

## Structure
- Shared package mips_pkg:
  - Opcode constants: OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_BNE 000101, OP_J 000010.
  - fetch_state_t enum (FETCH, HOLD).
  - Width constants: INSTR_W=32, OPCODE_W=6.
- One combinational sub-module, next_pc_calc:
  - Inputs: pc_plus4, beq, bne, jump, zero, branch_imm, jump_target.
  - Output: next_pc.
  - Unit-tested alone.

## Test plan
- Sequential fetch: reset with RESET_PC=0, ready=1, ack every HOLD cycle, no branches -> imem_addr 0,4,8,C on cycles 1,3,5,7; instr_valid pulses in between.
- Memory wait: ready held low 3 cycles in FETCH -> imem_req and imem_addr=0x10 stable all 3 cycles; instr_valid rises exactly one cycle after ready.
- beq taken at pc=0x20, branch_imm=16'hFFFE, zero=1 -> next fetch 0x1C. Same stimulus with zero=0 -> 0x24.
- bne taken at pc=0x40, branch_imm=3, zero=0 -> next fetch 0x50. Jump at pc=0x9000_0000, jump_target=26'h10 -> next fetch 0x9000_0040. Jump together with beq&zero -> jump target wins.
- Downstream stall: ack withheld 5 cycles -> instr/pc/instr_valid stable and no imem_req; stray ack in FETCH ignored.
- Reset in HOLD and in FETCH with imem_ready=1 the same cycle -> next cycle instr_valid=0, pc=RESET_PC; the response is discarded.
